prime_sieve_stepper: RTL and testbench
======================================

PRIME_SIEVE_STEPPER -- requirements
Module: prime_sieve_stepper

Interface
REQ-001 Parameter N, default 999999, inclusive upper bound of the sieve; legal range 3..2^AW-1.
REQ-002 Parameter AW, default 20, address/value width; 2^AW SHALL exceed N.
REQ-003 Parameter RD_LAT, default 2, read latency in cycles of the internal 1-bit flag memory; legal range 1..4.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rstn_signal  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level-sampled request to (re)build the sieve.
REQ-007 step  in  1  single-cycle request to advance to the next/previous prime.
REQ-008 dir  in  1  step direction, 0 = up, 1 = down; sampled with step.
REQ-009 busy  out  1  high in CLEAR, SIEVE, SEARCH.
REQ-010 ready  out  1  high only in READY.
REQ-011 prime_out  out  AW  current prime, binary.
REQ-012 prime_valid  out  1  one-cycle pulse when prime_out takes a new value.
REQ-013 wrap  out  1  one-cycle pulse, coincident with prime_valid, when the search crossed N (up) or 2 (down).

Function
REQ-014 States SHALL be IDLE, CLEAR, SIEVE_RD, SIEVE_MARK, READY, SEARCH.
REQ-015 IDLE: start=1 -> CLEAR; step ignored.
REQ-016 CLEAR: one flag write per cycle, value 0, addresses 0..N ascending; exactly N+1 cycles, then SIEVE_RD with i=2.
REQ-017 SIEVE_RD: while i*i <= N (product evaluated at 2*AW bits), read flag[i], wait RD_LAT cycles; flag 0 -> SIEVE_MARK with j=i*i; flag 1 -> i+1, stay; i*i > N -> READY.
REQ-018 SIEVE_MARK: write 1 to flag[j] once per cycle, j += i, until j > N (sum evaluated at AW+1 bits, no wrap); then i+1, SIEVE_RD.
REQ-019 Entering READY from sieve: prime_out = 2, prime_valid pulses once, wrap = 0.
REQ-020 READY: step=1 -> SEARCH with candidate c = prime_out+1 (dir 0) or prime_out-1 (dir 1); start=1 -> CLEAR (rebuild); start and step both high -> start wins.
REQ-021 SEARCH: each candidate costs exactly RD_LAT+1 cycles (address issue, RD_LAT wait, evaluate); flag 0 with c >= 2 -> prime_out = c, prime_valid pulse, READY.
REQ-022 SEARCH up: c > N -> c = 2, wrap latched; down: c < 2 -> c = N, wrap latched; wrap pulses with the following prime_valid.
REQ-023 step, dir, start SHALL be ignored while busy=1; no queuing.
REQ-024 prime_out SHALL hold its value between prime_valid pulses, including across start-triggered rebuilds until the new sieve completes.
REQ-025 Flag memory SHALL be inferred as simple dual-port (one write, one read port), depth N+1, no reset of contents.

Reset
REQ-026 rstn_signal low, any state: state = IDLE, busy = 0, ready = 0, prime_out = 0, prime_valid = 0, wrap = 0, i = 2, j = 0, write enable = 0, immediately (asynchronous).
REQ-027 Reset mid-CLEAR/SIEVE/SEARCH SHALL abandon the operation; stale flag contents are harmless because CLEAR always precedes SIEVE.

Verification (N=30, AW=5, RD_LAT=2)
REQ-028 Reset release, start=1 one cycle -> busy next edge, CLEAR lasts 31 cycles, sieve ends, prime_out=2, prime_valid one pulse, ready=1.
REQ-029 Ten up-steps from 2 -> prime_out 3,5,7,11,13,17,19,23,29,2; last step wrap=1; step 7->11 prime_valid 12 cycles after step edge (4 candidates x 3).
REQ-030 From 2, dir=1 step -> candidates 1 then 30..29, prime_out=29, wrap=1; next down-step -> 23, wrap=0.
REQ-031 step pulses during SEARCH and during CLEAR -> no effect; exactly one prime_valid per accepted step.
REQ-032 Assert rstn_signal low mid-SIEVE_MARK -> all outputs 0 within same cycle; new start -> full rebuild, prime_out=2 correct.
REQ-033 start and step high together in READY -> rebuild occurs, no search; after rebuild, flag contents match reference sieve for 0..30 (backdoor compare).

Source files
------------

// File: rtl/prime_sieve_stepper.sv
// Eratosthenes sieve over 0..N held in a 1-bit flag memory, then a
// stepper that walks up or down to the neighbouring prime with wrap.
module prime_sieve_stepper #(
   parameter int N      = 999999,
   parameter int AW     = 20,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rstn_signal,
   input  logic          start,
   input  logic          step,
   input  logic          dir,
   output logic          busy,
   output logic          ready,
   output logic [AW-1:0] prime_out,
   output logic          prime_valid,
   output logic          wrap
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SIEVE_RD,
      S_SIEVE_MARK,
      S_READY,
      S_SEARCH
   } state_t;

   localparam logic [AW-1:0]   LN  = AW'(N);
   localparam logic [AW:0]     LN1 = (AW+1)'(N);
   localparam logic [2*AW-1:0] LN2 = (2*AW)'(N);
   localparam logic [AW-1:0]   TWO = AW'(2);
   localparam logic [2:0]      LAT = 3'(RD_LAT);

   state_t          r_state;
   logic [AW-1:0]   r_i;
   logic [AW-1:0]   r_j;
   logic [AW-1:0]   r_c;
   logic [2:0]      r_ph;
   logic            r_dir;
   logic            r_wpend;
   logic            r_busy;
   logic            r_ready;
   logic [AW-1:0]   r_prime;
   logic            r_pv;
   logic            r_wrap;
   logic            r_we;
   logic [AW-1:0]   r_waddr;
   logic            r_wdata;
   logic            r_mem [0:N];
   logic [RD_LAT-1:0] r_rd;

   logic [2*AW-1:0] w_sq;
   logic [AW:0]     w_jn;
   logic            w_cin;
   logic [AW-1:0]   w_cnext;
   logic [AW-1:0]   w_raddr;
   logic            w_flag;
   logic            w_clear;
   logic            w_mark;

   assign w_sq    = {{AW{1'b0}}, r_i} * {{AW{1'b0}}, r_i};
   assign w_jn    = {1'b0, r_j} + {1'b0, r_i};
   assign w_cin   = (r_c >= TWO) && (r_c <= LN);
   assign w_cnext = r_dir ? r_c - 1'b1 : r_c + 1'b1;
   assign w_clear = (r_state == S_CLEAR);
   assign w_mark  = (r_state == S_SIEVE_MARK);
   assign w_flag  = r_rd[RD_LAT-1];

   // Out-of-range candidates still spend a full slot; read address 0 then.
   assign w_raddr = (r_state == S_SIEVE_RD) ? r_i :
                    (w_cin ? r_c : '0);

   assign busy        = r_busy;
   assign ready       = r_ready;
   assign prime_out   = r_prime;
   assign prime_valid = r_pv;
   assign wrap        = r_wrap;

   always_ff @(posedge clk) begin
      if (r_we) r_mem[r_waddr] <= r_wdata;
      r_rd[0] <= r_mem[w_raddr];
      for (int k = 1; k < RD_LAT; k++) r_rd[k] <= r_rd[k-1];
   end

   always_ff @(posedge clk or negedge rstn_signal) begin
      if (!rstn_signal) begin
         r_state <= S_IDLE;
         r_i     <= TWO;
         r_j     <= '0;
         r_c     <= '0;
         r_ph    <= '0;
         r_dir   <= 1'b0;
         r_wpend <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
         r_prime <= '0;
         r_pv    <= 1'b0;
         r_wrap  <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= 1'b0;
      end else begin
         r_pv    <= 1'b0;
         r_wrap  <= 1'b0;
         r_we    <= w_clear | w_mark;
         r_waddr <= r_j;
         r_wdata <= w_mark;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
                  r_j     <= '0;
               end
            end
            S_CLEAR: begin
               if (r_j == LN) begin
                  r_state <= S_SIEVE_RD;
                  r_i     <= TWO;
                  r_ph    <= '0;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_SIEVE_RD: begin
               if (r_ph == 3'd0) begin
                  if (w_sq > LN2) begin
                     r_state <= S_READY;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                     r_prime <= TWO;
                     r_pv    <= 1'b1;
                  end else begin
                     r_ph <= 3'd1;
                  end
               end else if (r_ph != LAT) begin
                  r_ph <= r_ph + 3'd1;
               end else begin
                  r_ph <= '0;
                  if (!w_flag) begin
                     r_state <= S_SIEVE_MARK;
                     r_j     <= w_sq[AW-1:0];
                  end else begin
                     r_i <= r_i + 1'b1;
                  end
               end
            end
            S_SIEVE_MARK: begin
               if (w_jn > LN1) begin
                  r_state <= S_SIEVE_RD;
                  r_i     <= r_i + 1'b1;
               end else begin
                  r_j <= w_jn[AW-1:0];
               end
            end
            S_READY: begin
               if (start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_j     <= '0;
               end else if (step) begin
                  r_state <= S_SEARCH;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
                  r_dir   <= dir;
                  r_wpend <= 1'b0;
                  r_ph    <= '0;
                  r_c     <= dir ? r_prime - 1'b1 : r_prime + 1'b1;
               end
            end
            S_SEARCH: begin
               if (r_ph != LAT) begin
                  r_ph <= r_ph + 3'd1;
               end else begin
                  r_ph <= '0;
                  if (!w_cin) begin
                     r_c     <= r_dir ? LN : TWO;
                     r_wpend <= 1'b1;
                  end else if (!w_flag) begin
                     r_state <= S_READY;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                     r_prime <= r_c;
                     r_pv    <= 1'b1;
                     r_wrap  <= r_wpend;
                  end else begin
                     r_c <= w_cnext;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prime_sieve_stepper.sv
// Directed and randomized checks of prime_sieve_stepper against a
// trial-division prime model, N=30, AW=5, RD_LAT=2.
module tb_prime_sieve_stepper;

   localparam int N      = 30;
   localparam int AW     = 5;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rstn_signal = 1'b1;
   logic          start = 1'b0;
   logic          step = 1'b0;
   logic          dir = 1'b0;
   logic          busy;
   logic          ready;
   logic [AW-1:0] prime_out;
   logic          prime_valid;
   logic          wrap;

   int checks = 0;
   int failures = 0;
   int p;

   always #5 clk = ~clk;

   prime_sieve_stepper #(.N(N), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk         (clk),
      .rstn_signal (rstn_signal),
      .start       (start),
      .step        (step),
      .dir         (dir),
      .busy        (busy),
      .ready       (ready),
      .prime_out   (prime_out),
      .prime_valid (prime_valid),
      .wrap        (wrap)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_prime(input int v);
      if (v < 2) return 1'b0;
      for (int d = 2; d * d <= v; d++)
         if (v % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Walk candidates; an out-of-range candidate costs a slot then wraps.
   task automatic model_next(input int from, input bit d,
                             output int q, output bit w, output int cands);
      int c;
      c = d ? from - 1 : from + 1;
      w = 1'b0;
      cands = 0;
      forever begin
         cands++;
         if (c < 2 || c > N) begin
            w = 1'b1;
            c = d ? N : 2;
         end else if (is_prime(c)) begin
            break;
         end else begin
            c = d ? c - 1 : c + 1;
         end
      end
      q = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rebuild(input bit with_step, input int old_po);
      int n;
      int nclr;
      bit held;
      start = 1'b1;
      step  = with_step;
      dir   = 1'($urandom % 2);
      tick();
      start = 1'b0;
      step  = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("ready_after_start", ready, 0);
      nclr = dut.w_clear ? 1 : 0;
      n    = 0;
      held = 1'b1;
      while (!ready && n < 5000) begin
         if (prime_out != AW'(old_po) || prime_valid) held = 1'b0;
         step = ($urandom % 3 == 0);
         dir  = 1'($urandom % 2);
         tick();
         n++;
         if (dut.w_clear) nclr++;
      end
      step = 1'b0;
      chk("rebuild_done", ready, 1);
      chk("clear_cycles", nclr, N + 1);
      chk("po_held_in_rebuild", held, 1);
      chk("sieve_prime", prime_out, 2);
      chk("sieve_pv", prime_valid, 1);
      chk("sieve_wrap", wrap, 0);
      chk("sieve_busy", busy, 0);
      tick();
      chk("sieve_pv_single", prime_valid, 0);
      chk("sieve_ready_hold", ready, 1);
   endtask

   task automatic do_step(input bit d, input int from, output int to);
      int  q;
      bit  w;
      int  cands;
      int  n;
      model_next(from, d, q, w, cands);
      step = 1'b1;
      dir  = d;
      tick();
      step = 1'b0;
      chk("search_busy", busy, 1);
      chk("search_ready", ready, 0);
      n = 0;
      do begin
         step = ($urandom % 4 == 0);
         dir  = 1'($urandom % 2);
         tick();
         n++;
      end while (!prime_valid && n < 500);
      step = 1'b0;
      chk("step_prime", prime_out, q);
      chk("step_wrap", wrap, w);
      chk("step_latency", n, cands * (RD_LAT + 1));
      chk("step_ready", ready, 1);
      tick();
      chk("step_pv_single", prime_valid, 0);
      chk("step_wrap_single", wrap, 0);
      chk("step_po_hold", prime_out, q);
      to = q;
   endtask

   initial begin
      int up_exp [10];
      int nxt;
      int n;
      up_exp = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 2};

      #1 rstn_signal = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 0);
      chk("rst_prime", prime_out, 0);
      chk("rst_pv", prime_valid, 0);
      chk("rst_wrap", wrap, 0);
      #19 rstn_signal = 1'b1;
      tick();

      step = 1'b1;
      tick();
      step = 1'b0;
      chk("idle_step_busy", busy, 0);
      chk("idle_step_ready", ready, 0);

      rebuild(1'b0, 0);
      p = 2;

      for (int k = 0; k < 10; k++) begin
         do_step(1'b0, p, nxt);
         chk("up_seq", prime_out, up_exp[k]);
         p = nxt;
      end

      do_step(1'b1, p, nxt);
      chk("down_from2", prime_out, 29);
      p = nxt;
      do_step(1'b1, p, nxt);
      chk("down_from29", prime_out, 23);
      p = nxt;

      for (int k = 0; k < 30; k++) begin
         do_step(1'($urandom % 2), p, nxt);
         p = nxt;
      end

      rebuild(1'b1, p);
      p = 2;
      for (int k = 0; k <= N; k++)
         chk("flag_backdoor", dut.r_mem[k], (k >= 4 && !is_prime(k)) ? 1 : 0);
      do_step(1'b0, p, nxt);
      p = nxt;

      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!dut.w_mark && n < 2000) begin
         tick();
         n++;
      end
      chk("reached_mark", dut.w_mark, 1);
      #2 rstn_signal = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_prime", prime_out, 0);
      chk("midrst_pv", prime_valid, 0);
      chk("midrst_wrap", wrap, 0);
      chk("midrst_we", dut.r_we, 0);
      #3 rstn_signal = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);

      rebuild(1'b0, 0);
      p = 2;
      for (int k = 0; k < 12; k++) begin
         do_step(1'($urandom % 2), p, nxt);
         p = nxt;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
